// File: rtl/processing_array_evq_if.sv
// Event stream handshake between the processing array and its consumer.
// Transfer happens on a clock edge where evt_valid && evt_ready; head fields hold while stalled.
interface processing_array_evq_if #(
  parameter int CH_W = 2,
  parameter int TS_W = 16
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_chan;
  logic [1:0]      evt_code;
  logic [TS_W-1:0] evt_time;

  modport master (output evt_valid, evt_chan, evt_code, evt_time, input evt_ready);
  modport slave  (input evt_valid, evt_chan, evt_code, evt_time, output evt_ready);
endinterface

// File: rtl/processing_array_evq.sv
// Multi-channel spike processing array: per-channel detector units, pending-event capture,
// round-robin arbitration and a timestamped event FIFO with registered head outputs.
module processing_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_data_in,
  input  logic [15:0] i_threshold_in,
  input  logic [7:0]  i_class_a_thresh_in,
  input  logic [7:0]  i_class_b_thresh_in,
  input  logic [15:0] i_timeout_period_in,
  output logic        o_spike_detection,
  output logic [1:0]  o_event_out
);
  logic [15:0] r_hold;
  logic [7:0]  w_amp;
  logic        w_fire;

  // Amplitude saturates to 8 bits for classification; hold-off suppresses re-triggering.
  assign o_spike_detection = i_data_in > i_threshold_in;
  assign w_amp  = (|i_data_in[15:8]) ? 8'hFF : i_data_in[7:0];
  assign w_fire = o_spike_detection && (r_hold == 16'd0);

  always_comb begin
    o_event_out = 2'b00;
    if (w_fire) begin
      if (w_amp >= i_class_b_thresh_in)      o_event_out = 2'b11;
      else if (w_amp >= i_class_a_thresh_in) o_event_out = 2'b10;
      else                                   o_event_out = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  r_hold <= 16'd0;
    else if (w_fire)          r_hold <= i_timeout_period_in;
    else if (r_hold != 16'd0) r_hold <= r_hold - 16'd1;
  end
endmodule

module processing_array_evq #(
  parameter int  NUM_UNITS      = 4,
  parameter int  FIFO_DEPTH     = 8,
  parameter int  TS_W           = 16,
  parameter logic [15:0] DEFAULT_THRESH = 16'd200,
  localparam int CH_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_UNITS*16-1:0] i_data_in_wide,
  input  logic [7:0]             i_class_a_thresh_in,
  input  logic [7:0]             i_class_b_thresh_in,
  input  logic [15:0]            i_timeout_period_in,
  input  logic [NUM_UNITS-1:0]   i_chan_enable,
  input  logic                   i_cfg_we,
  input  logic [CH_W-1:0]        i_cfg_addr,
  input  logic [15:0]            i_cfg_data,
  output logic [NUM_UNITS-1:0]   o_spike_detection_array,
  output logic [2*NUM_UNITS-1:0] o_event_out_array,
  processing_array_evq_if.master o_evt,
  output logic [LVL_W-1:0]       o_fifo_level,
  output logic                   o_overflow_sticky,
  input  logic                   i_overflow_clr
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CH_W + 2 + TS_W;

  logic [15:0]      r_thresh [NUM_UNITS];
  logic [1:0]       w_event  [NUM_UNITS];
  logic [TS_W-1:0]  r_ts;
  logic [NUM_UNITS-1:0] r_pend;
  logic [1:0]       r_pcode  [NUM_UNITS];
  logic [TS_W-1:0]  r_pts    [NUM_UNITS];
  logic [CH_W-1:0]  r_ptr;
  logic [ENT_W-1:0] r_mem    [FIFO_DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [LVL_W-1:0] r_level;
  logic [ENT_W-1:0] r_head, w_head_nxt, w_push_ent;
  logic             r_valid, w_valid_nxt, r_ovf;
  logic             w_grant_any, w_full, w_push, w_pop, w_ovf;
  logic [CH_W-1:0]  w_grant, w_idx, w_next_ptr;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    processing_unit u_unit (
      .clk                 (clk),
      .rst                 (rst),
      .i_data_in           (i_data_in_wide[16*g +: 16]),
      .i_threshold_in      (r_thresh[g]),
      .i_class_a_thresh_in (i_class_a_thresh_in),
      .i_class_b_thresh_in (i_class_b_thresh_in),
      .i_timeout_period_in (i_timeout_period_in),
      .o_spike_detection   (o_spike_detection_array[g]),
      .o_event_out         (w_event[g])
    );
    assign o_event_out_array[2*g +: 2] = w_event[g];
  end

  // First pending channel at or after the round-robin pointer wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_idx = CH_W'((int'(r_ptr) + k) % NUM_UNITS);
      if (!w_grant_any && r_pend[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push     = w_grant_any && !w_full;
  assign w_pop      = r_valid && o_evt.evt_ready;
  assign w_push_ent = {w_grant, r_pcode[w_grant], r_pts[w_grant]};
  assign w_next_ptr = (w_grant == CH_W'(NUM_UNITS - 1)) ? '0 : w_grant + CH_W'(1);

  always_comb begin
    w_ovf = 1'b0;
    for (int j = 0; j < NUM_UNITS; j++)
      if (i_chan_enable[j] && w_event[j] != 2'b00 && r_pend[j] && !(w_push && w_grant == CH_W'(j)))
        w_ovf = 1'b1;
  end

  // Head register always mirrors the oldest stored entry; cleared when the FIFO empties.
  always_comb begin
    w_head_nxt  = r_head;
    w_valid_nxt = r_valid;
    if (w_pop) begin
      if (r_level >= LVL_W'(2)) begin
        w_head_nxt  = r_mem[r_rd + AW'(1)];
        w_valid_nxt = 1'b1;
      end else if (w_push) begin
        w_head_nxt  = w_push_ent;
        w_valid_nxt = 1'b1;
      end else begin
        w_head_nxt  = '0;
        w_valid_nxt = 1'b0;
      end
    end else if (r_level == '0 && w_push) begin
      w_head_nxt  = w_push_ent;
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_UNITS; j++) begin
        r_thresh[j] <= DEFAULT_THRESH;
        r_pcode[j]  <= 2'b00;
        r_pts[j]    <= '0;
      end
      r_ts    <= '0;
      r_pend  <= '0;
      r_ptr   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_head  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (i_cfg_we && i_cfg_addr == CH_W'(j)) r_thresh[j] <= i_cfg_data;
        if (!i_chan_enable[j]) begin
          r_pend[j] <= 1'b0;
        end else if (w_event[j] != 2'b00) begin
          r_pend[j]  <= 1'b1;
          r_pcode[j] <= w_event[j];
          r_pts[j]   <= r_ts;
        end else if (w_push && w_grant == CH_W'(j)) begin
          r_pend[j] <= 1'b0;
        end
      end
      if (w_push) begin
        r_ptr <= w_next_ptr;
        r_wr  <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      r_head  <= w_head_nxt;
      r_valid <= w_valid_nxt;
      if (w_ovf)               r_ovf <= 1'b1;
      else if (i_overflow_clr) r_ovf <= 1'b0;
    end
  end

  assign o_evt.evt_valid = r_valid;
  assign o_evt.evt_chan  = r_head[ENT_W-1 -: CH_W];
  assign o_evt.evt_code  = r_head[TS_W +: 2];
  assign o_evt.evt_time  = r_head[TS_W-1:0];
  assign o_fifo_level      = r_level;
  assign o_overflow_sticky = r_ovf;
endmodule

// File: tb/tb_processing_array_evq.sv
// Directed bench for processing_array_evq: event ordering, latency, overflow, config, masking, wrap, reset.
module tb_processing_array_evq;
  localparam int N    = 4;
  localparam int CH_W = 2;
  localparam int TS_W = 16;
  localparam int LVL_W = 4;
  localparam int ENT_W = CH_W + 2 + TS_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N*16-1:0]  data_in_wide = '0;
  logic [N-1:0]     chan_enable = '1;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_addr = '0;
  logic [15:0]      cfg_data = '0;
  logic [N-1:0]     spike_arr;
  logic [2*N-1:0]   event_arr;
  logic [LVL_W-1:0] fifo_level;
  logic             ovf_sticky;
  logic             ovf_clr = 1'b0;

  logic [ENT_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [TS_W-1:0]  tb_ts = '0;
  logic [TS_W-1:0]  t;
  logic             stalled = 1'b0;
  logic [ENT_W-1:0] prev_head = '0;

  processing_array_evq_if #(.CH_W(CH_W), .TS_W(TS_W)) evt_if ();

  processing_array_evq dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_data_in_wide          (data_in_wide),
    .i_class_a_thresh_in     (8'd240),
    .i_class_b_thresh_in     (8'd250),
    .i_timeout_period_in     (16'd0),
    .i_chan_enable           (chan_enable),
    .i_cfg_we                (cfg_we),
    .i_cfg_addr              (cfg_addr),
    .i_cfg_data              (cfg_data),
    .o_spike_detection_array (spike_arr),
    .o_event_out_array       (event_arr),
    .o_evt                   (evt_if),
    .o_fifo_level            (fifo_level),
    .o_overflow_sticky       (ovf_sticky),
    .i_overflow_clr          (ovf_clr)
  );

  // clock / reset and a reference timestamp
  always #5 clk = ~clk;
  always @(posedge clk) tb_ts <= rst ? '0 : tb_ts + 16'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks; all stimulus changes happen 1ns after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [N-1:0] mask, input logic [15:0] amp);
    for (int j = 0; j < N; j++) data_in_wide[16*j +: 16] = mask[j] ? amp : 16'd0;
  endtask

  task automatic fire(input logic [N-1:0] mask, input logic [15:0] amp, output logic [TS_W-1:0] ts);
    set_data(mask, amp);
    ts = tb_ts;
    step(1);
    set_data('0, 16'd0);
  endtask

  task automatic exp_push(input int ch, input logic [1:0] code, input logic [TS_W-1:0] ts);
    exp_q.push_back({CH_W'(ch), code, ts});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !evt_if.evt_valid) break;
      step(1);
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
  endtask

  // scoreboard: compare each accepted head against the expected queue; check stall stability
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && evt_if.evt_valid)
        check("head_stable", 32'({evt_if.evt_chan, evt_if.evt_code, evt_if.evt_time}), 32'(prev_head));
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("evt_entry", 32'({evt_if.evt_chan, evt_if.evt_code, evt_if.evt_time}), 32'(exp_q.pop_front()));
      end
      stalled   = evt_if.evt_valid && !evt_if.evt_ready;
      prev_head = {evt_if.evt_chan, evt_if.evt_code, evt_if.evt_time};
    end
  end

  initial begin
    evt_if.evt_ready = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    check("rst_head", 32'({evt_if.evt_chan, evt_if.evt_code, evt_if.evt_time}), 32'd0);

    // 1: single event on ch1 at ts=10, two-cycle latency
    for (int i = 0; i < 20 && tb_ts != 16'd10; i++) step(1);
    fire(4'b0010, 16'd210, t);
    exp_push(1, 2'b01, 16'd10);
    @(negedge clk);
    check("lat_n1_valid", 32'(evt_if.evt_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(evt_if.evt_valid), 32'd1);
    check("lat_chan", 32'(evt_if.evt_chan), 32'd1);
    check("lat_code", 32'(evt_if.evt_code), 32'd1);
    check("lat_time", 32'(evt_if.evt_time), 32'd10);
    step(1);
    wait_empty("t1_drain");

    // 2: round-robin ordering
    do_reset();
    fire(4'b1111, 16'd210, t);
    for (int j = 0; j < N; j++) exp_push(j, 2'b01, t);
    wait_empty("t2_burst");
    fire(4'b0010, 16'd245, t);
    exp_push(1, 2'b10, t);
    wait_empty("t2_single");
    fire(4'b1001, 16'd300, t);
    exp_push(3, 2'b11, t);
    exp_push(0, 2'b11, t);
    wait_empty("t2_rr_wrap");

    // 3: FIFO full, pending overwrite, drain and sticky clear
    do_reset();
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fire(N'(1) << (i % N), 16'd210, t);
      exp_push(i % N, 2'b01, t);
    end
    fire(4'b0001, 16'd245, t);
    fire(4'b0010, 16'd245, t);
    step(3);
    check("full_level", 32'(fifo_level), 32'd8);
    check("pre_ovf", 32'(ovf_sticky), 32'd0);
    fire(4'b0011, 16'd300, t);
    exp_push(0, 2'b11, t);
    exp_push(1, 2'b11, t);
    @(negedge clk);
    check("ovf_set", 32'(ovf_sticky), 32'd1);
    check("full_hold", 32'(fifo_level), 32'd8);
    step(1);
    evt_if.evt_ready = 1'b1;
    wait_empty("t3_drain");
    check("drain_level", 32'(fifo_level), 32'd0);
    check("ovf_kept", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(ovf_sticky), 32'd0);
    step(1);

    // 4: runtime threshold programming
    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 16'd50;
    step(1);
    cfg_we = 1'b0;
    set_data(4'b0101, 16'd100);
    t = tb_ts;
    @(negedge clk);
    check("cfg_spike", 32'(spike_arr), 32'h4);
    check("cfg_event", 32'(event_arr), 32'h10);
    step(1);
    set_data('0, 16'd0);
    exp_push(2, 2'b01, t);
    wait_empty("t4_cfg");

    // 5: channel masking leaves raw outputs alone
    chan_enable = 4'b0111;
    set_data(4'b1010, 16'd245);
    t = tb_ts;
    @(negedge clk);
    check("mask_raw_ev", 32'(event_arr), 32'h88);
    check("mask_raw_spk", 32'(spike_arr), 32'hA);
    step(1);
    set_data('0, 16'd0);
    exp_push(1, 2'b10, t);
    wait_empty("t5_mask");
    chan_enable = 4'b1111;

    // 6: timestamp wrap, then reset with entries held
    for (int i = 0; i < 70000 && tb_ts != 16'hFFFF; i++) step(1);
    fire(4'b0001, 16'd210, t);
    exp_push(0, 2'b01, 16'hFFFF);
    fire(4'b0010, 16'd210, t);
    exp_push(1, 2'b01, 16'h0000);
    wait_empty("t6_wrap");
    evt_if.evt_ready = 1'b0;
    fire(4'b0111, 16'd210, t);
    step(4);
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    check("pre_rst_valid", 32'(evt_if.evt_valid), 32'd1);
    do_reset();
    @(negedge clk);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("mid_rst_head", 32'({evt_if.evt_chan, evt_if.evt_code, evt_if.evt_time}), 32'd0);
    step(4);
    check("post_rst_level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
